// File: rtl/sm_user_port_loader_if.sv
// Bundle of the loader's control, source-stream and RAM user-port signals.
// The loader itself connects through the master modport; the environment
// (RAM, source, controller) sits on the slave side.
interface sm_user_port_loader_if;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        verify_en;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] userAddr;
    logic        userWe;
    logic [31:0] userWData;
    logic [31:0] userRData;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] err_sum;

    modport master (
        input  start, base_addr, word_count, verify_en, in_valid, in_data, userRData,
        output in_ready, userAddr, userWe, userWData, busy, done, error, err_sum
    );

    modport slave (
        output start, base_addr, word_count, verify_en, in_valid, in_data, userRData,
        input  in_ready, userAddr, userWe, userWData, busy, done, error, err_sum
    );
endinterface

// File: rtl/sm_user_port_loader.sv
// Streams word_count source words into a RAM user port starting at base_addr,
// optionally reads them all back and compares the readback checksum against
// the write checksum. A mismatch raises error and captures err_sum.
module sm_user_port_loader #(
    parameter int ADDR_STEP = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sm_user_port_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, CHECK, FIN} state_t;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);
    localparam logic [1:0]  LAT  = 2'(RD_LAT);

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wsum_q, wsum_d;
    logic [31:0] rsum_q, rsum_d;
    logic [31:0] err_sum_q, err_sum_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  lat_q, lat_d;
    logic        verify_q, verify_d;
    logic        error_q, error_d;
    logic        done_q, done_d;

    logic handshake;
    logic last_idx;
    logic rd_sample;

    // A beat is taken whenever the source is valid while writing; the RAM
    // write enable follows it in the same cycle.
    assign handshake = (state_q == WRITE) && bus.in_valid;
    assign last_idx  = (idx_q == cnt_q - 16'd1);
    // Read data is captured on the final cycle the address has been held:
    // the issue cycle itself when there is no read latency.
    assign rd_sample = ((state_q == RD_ISSUE) && (LAT == 2'd0)) ||
                       ((state_q == RD_WAIT)  && (lat_q == LAT));

    assign bus.in_ready  = (state_q == WRITE);
    assign bus.userWe    = handshake;
    assign bus.userWData = (state_q == WRITE) ? bus.in_data : 32'd0;
    assign bus.userAddr  = addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.err_sum   = err_sum_q;

    // Next-state and datapath: addr_q always holds the address being driven,
    // and is left untouched on the final beat/read so it persists afterwards.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        addr_d    = addr_q;
        wsum_d    = wsum_q;
        rsum_d    = rsum_q;
        err_sum_d = err_sum_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        verify_d  = verify_q;
        error_d   = error_q;
        done_d    = (state_q == FIN);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d    = bus.base_addr;
                    cnt_d     = bus.word_count;
                    verify_d  = bus.verify_en;
                    idx_d     = 16'd0;
                    wsum_d    = 32'd0;
                    rsum_d    = 32'd0;
                    error_d   = 1'b0;
                    err_sum_d = 32'd0;
                    if (bus.word_count == 16'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = WRITE;
                        addr_d  = bus.base_addr;
                    end
                end
            end
            WRITE: begin
                if (handshake) begin
                    wsum_d = wsum_q + bus.in_data;
                    if (last_idx) begin
                        if (verify_q) begin
                            state_d = RD_ISSUE;
                            idx_d   = 16'd0;
                            addr_d  = base_q;
                            rsum_d  = 32'd0;
                        end else begin
                            state_d = FIN;
                        end
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        addr_d = addr_q + STEP;
                    end
                end
            end
            RD_ISSUE: begin
                if (!rd_sample) begin
                    state_d = RD_WAIT;
                    lat_d   = 2'd1;
                end
            end
            RD_WAIT: begin
                if (!rd_sample) begin
                    lat_d = lat_q + 2'd1;
                end
            end
            CHECK: begin
                if (rsum_q != wsum_q) begin
                    error_d   = 1'b1;
                    err_sum_d = rsum_q;
                end
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_sample) begin
            rsum_d = rsum_q + bus.userRData;
            if (last_idx) begin
                state_d = CHECK;
            end else begin
                idx_d   = idx_q + 16'd1;
                addr_d  = addr_q + STEP;
                state_d = RD_ISSUE;
            end
        end
    end

    // State and registered outputs; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= 32'd0;
            addr_q    <= 32'd0;
            wsum_q    <= 32'd0;
            rsum_q    <= 32'd0;
            err_sum_q <= 32'd0;
            cnt_q     <= 16'd0;
            idx_q     <= 16'd0;
            lat_q     <= 2'd0;
            verify_q  <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            wsum_q    <= wsum_d;
            rsum_q    <= rsum_d;
            err_sum_q <= err_sum_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            verify_q  <= verify_d;
            error_q   <= error_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_sm_user_port_loader.sv
// Bench for sm_user_port_loader: a RAM model with configurable read latency,
// a per-cycle expectation generator derived from load phases, and one
// compare process checking every output on every cycle of each load.
module tb_sm_user_port_loader;
    localparam int TB_RD_LAT = 2;
    localparam int STEP      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sm_user_port_loader_if bus ();

    sm_user_port_loader #(.ADDR_STEP(STEP), .RD_LAT(TB_RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RAM model: 1024 words indexed by address bits [11:2], optional corruption
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [0:3];
    int          wr_count = 0;
    bit          corrupt_on = 1'b0;
    logic [31:0] corrupt_addr = 32'd0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (corrupt_on && a == corrupt_addr) return 32'd0;
        return mem[a[11:2]];
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= rd_word(bus.userAddr);
        for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.userWe) begin
            mem[bus.userAddr[11:2]] <= bus.userWData;
            wr_count <= wr_count + 1;
        end
    end
    assign bus.userRData = rd_pipe[TB_RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle expectations written by the driver, checked at negedge
    bit          chk_en = 1'b0;
    bit          exp_busy, exp_done, exp_in_ready, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_err_sum;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     32'(bus.busy),     32'(exp_busy));
            chk("done",     32'(bus.done),     32'(exp_done));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
            chk("userWe",   32'(bus.userWe),   32'(exp_we));
            chk("userAddr", bus.userAddr,      exp_addr);
            if (exp_we) chk("userWData", bus.userWData, exp_wdata);
            chk("error",    32'(bus.error),    32'(exp_err));
            chk("err_sum",  bus.err_sum,       exp_err_sum);
        end
    end

    logic [31:0] data_arr [0:15];
    logic [31:0] prev_last_addr = 32'd0;
    bit          prev_err = 1'b0;
    logic [31:0] prev_err_sum = 32'd0;
    int          load_no = 0;

    // One load: start pulse in cycle 0, then cycles 1..D where D is the done cycle.
    task automatic run_load(input logic [31:0] base, input int cnt, input bit ver,
                            input int vmode, input int corrupt_idx);
        bit          vq[$];
        bit          v;
        bit          e;
        int          ones, W, D, beats;
        logic [31:0] wsum, rsum, last_addr;
        ones = 0;
        while (ones < cnt) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (vq.size() % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            vq.push_back(v);
            if (v) ones++;
        end
        W = vq.size();
        wsum = 32'd0;
        rsum = 32'd0;
        for (int k = 0; k < cnt; k++) begin
            wsum = wsum + data_arr[k];
            rsum = rsum + ((k == corrupt_idx) ? 32'd0 : data_arr[k]);
        end
        e = ver && (cnt != 0) && (rsum != wsum);
        if (cnt == 0)  D = 2;
        else if (ver)  D = W + cnt * (1 + TB_RD_LAT) + 3;
        else           D = W + 2;
        last_addr    = (cnt == 0) ? prev_last_addr : base + 32'((cnt - 1) * STEP);
        corrupt_on   = (corrupt_idx >= 0);
        corrupt_addr = base + 32'(corrupt_idx * STEP);
        beats = 0;
        for (int n = 0; n <= D; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                bus.start      = 1'b1;
                bus.base_addr  = base;
                bus.word_count = 16'(cnt);
                bus.verify_en  = ver;
            end else begin
                bus.start      = (n < D) && ($urandom_range(0, 3) == 0);
                bus.base_addr  = $urandom;
                bus.word_count = 16'($urandom_range(0, 20));
                bus.verify_en  = 1'($urandom_range(0, 1));
            end
            exp_in_ready = (cnt != 0) && (n >= 1) && (n <= W);
            v = exp_in_ready ? vq[n-1] : 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = (exp_in_ready && v) ? data_arr[beats] : $urandom;
            exp_busy  = (n >= 1) && (n < D);
            exp_done  = (n == D);
            exp_we    = exp_in_ready && v;
            exp_wdata = data_arr[beats];
            if (n == 0)
                exp_addr = prev_last_addr;
            else if (exp_in_ready)
                exp_addr = base + 32'(beats * STEP);
            else if (ver && cnt != 0 && n <= W + cnt * (1 + TB_RD_LAT))
                exp_addr = base + 32'(((n - W - 1) / (1 + TB_RD_LAT)) * STEP);
            else
                exp_addr = last_addr;
            if (n == 0) begin
                exp_err = prev_err;  exp_err_sum = prev_err_sum;
            end else if (n < D - 1) begin
                exp_err = 1'b0;      exp_err_sum = 32'd0;
            end else begin
                exp_err = e;         exp_err_sum = e ? rsum : 32'd0;
            end
            chk_en = 1'b1;
            if (exp_we) beats++;
        end
        @(posedge clk);
        #1;
        chk_en       = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        corrupt_on   = 1'b0;
        prev_last_addr = last_addr;
        prev_err       = e;
        prev_err_sum   = e ? rsum : 32'd0;
        $display("load %0d base=%h count=%0d verify=%0d corrupt_idx=%0d wsum=%h rsum=%h exp_error=%0d done_cycle=%0d",
                 load_no, base, cnt, ver, corrupt_idx, wsum, rsum, e, D);
        load_no++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int cnt;
        int cidx;
        bus.start = 1'b0;  bus.base_addr = 32'd0;  bus.word_count = 16'd0;
        bus.verify_en = 1'b0;  bus.in_valid = 1'b1;  bus.in_data = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_userWe",   32'(bus.userWe),   32'd0);
        chk("rst_userAddr", bus.userAddr,      32'd0);
        chk("rst_userWData", bus.userWData,    32'd0);
        chk("rst_error",    32'(bus.error),    32'd0);
        chk("rst_err_sum",  bus.err_sum,       32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // single word, verified
        data_arr[0] = 32'h00110011;
        run_load(32'h4, 1, 1'b1, 0, -1);
        chk("t1_mem4",  mem[1], 32'h00110011);
        chk("t1_error", 32'(bus.error), 32'd0);

        // four words with gapped valid
        for (int k = 0; k < 4; k++) data_arr[k] = 32'(k + 1);
        run_load(32'h0, 4, 1'b1, 1, -1);
        chk("t2_mem0", mem[0], 32'd1);
        chk("t2_mem4", mem[1], 32'd2);
        chk("t2_mem8", mem[2], 32'd3);
        chk("t2_memC", mem[3], 32'd4);
        chk("t2_sum",  mem[0] + mem[1] + mem[2] + mem[3], 32'd10);

        // zero-length load: no writes at all
        wc = wr_count;
        run_load(32'h40, 0, 1'b1, 0, -1);
        chk("t3_no_writes", 32'(wr_count), 32'(wc));

        // corrupted readback of word at 0x4
        data_arr[0] = 32'hA5A50001;
        data_arr[1] = 32'h00000777;
        run_load(32'h0, 2, 1'b1, 0, 1);
        chk("t4_error",   32'(bus.error), 32'd1);
        chk("t4_err_sum", bus.err_sum,    32'hA5A50001);

        // address wrap
        data_arr[0] = 32'hCAFE0001;
        data_arr[1] = 32'hCAFE0002;
        run_load(32'hFFFFFFFC, 2, 1'b0, 2, -1);
        chk("t5_mem_top",  mem[1023], 32'hCAFE0001);
        chk("t5_mem_zero", mem[0],    32'hCAFE0002);

        // reset after two of four beats
        wc = wr_count;
        bus.start = 1'b1;  bus.base_addr = 32'h100;  bus.word_count = 16'd4;
        bus.verify_en = 1'b1;  bus.in_valid = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h11;
        @(posedge clk); #1 bus.in_data = 32'h22;
        @(posedge clk); #1 bus.in_data = 32'h33;
        #2 rst = 1'b1;
        #1;
        chk("t6_userWe",   32'(bus.userWe),   32'd0);
        chk("t6_busy",     32'(bus.busy),     32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t6_userAddr", bus.userAddr,      32'd0);
        chk("t6_writes",   32'(wr_count),     32'(wc + 2));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_done_after", 32'(bus.done), 32'd0);
            chk("t6_busy_after", 32'(bus.busy), 32'd0);
        end
        chk("t6_writes_after", 32'(wr_count), 32'(wc + 2));
        chk("t6_mem104",       mem[65],       32'h22);
        bus.in_valid   = 1'b0;
        prev_last_addr = 32'd0;
        prev_err       = 1'b0;
        prev_err_sum   = 32'd0;

        // new load after abort, then randomized loads
        for (int k = 0; k < 4; k++) data_arr[k] = $urandom;
        run_load(32'h200, 4, 1'b1, 2, -1);
        for (int r = 0; r < 14; r++) begin
            cnt = $urandom_range(0, 10);
            for (int k = 0; k < 16; k++) data_arr[k] = $urandom;
            cidx = (cnt > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, cnt - 1) : -1;
            run_load($urandom, cnt, 1'($urandom_range(0, 1)), 2, cidx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sm_user_port_loader.md
SM_USER_PORT_LOADER -- requirements
Module: sm_user_port_loader

Interface
REQ-001 Parameter ADDR_STEP, default 4, byte increment between consecutive words on userAddr.
REQ-002 Parameter RD_LAT, default 1, cycles from userAddr valid to userRData valid; legal range 0..3.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle pulse; launches a load when IDLE.
REQ-006 base_addr  input  32  byte address of first word; sampled on accepted start.
REQ-007 word_count  input  16  number of words; sampled on accepted start.
REQ-008 verify_en  input  1  1 = run readback-checksum phase after writes; sampled on accepted start.
REQ-009 in_valid  input  1  source word available.
REQ-010 in_data  input  32  source word.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 userAddr  output  32  byte address to RAM user port.
REQ-013 userWe  output  1  RAM user-port write enable.
REQ-014 userWData  output  32  RAM user-port write data.
REQ-015 userRData  input  32  RAM user-port read data.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at completion.
REQ-018 error  output  1  checksum mismatch flag; held until next accepted start.
REQ-019 err_sum  output  32  readback checksum captured on mismatch.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, RD_ISSUE, RD_WAIT, CHECK, FIN.
REQ-021 IDLE->WRITE on start when word_count!=0; IDLE->FIN on start when word_count==0; start outside IDLE SHALL be ignored.
REQ-022 WRITE: in_ready=1; handshake = in_valid&in_ready; userWe = handshake, combinational, same cycle.
REQ-023 WRITE: userAddr = base_addr + idx*ADDR_STEP, userWData = in_data, idx = number of beats already accepted.
REQ-024 Address arithmetic SHALL be 32-bit modulo; wrap past 0xFFFFFFFC is legal and silent.
REQ-025 Each accepted beat SHALL add in_data to a 32-bit modulo write checksum wsum, initialised to 0 on accepted start.
REQ-026 After beat word_count-1: verify_en=1 -> RD_ISSUE with idx=0, rsum=0; verify_en=0 -> FIN.
REQ-027 in_valid low in WRITE SHALL stall without timeout; userWe=0 on stall cycles.
REQ-028 RD_ISSUE: userWe=0, userAddr=base_addr+idx*ADDR_STEP, held constant through RD_WAIT.
REQ-029 RD_WAIT SHALL last RD_LAT cycles (0 = skipped); userRData sampled on the last cycle of that address hold and added to rsum.
REQ-030 After last read -> CHECK; CHECK: rsum!=wsum -> error=1, err_sum=rsum; then FIN.
REQ-031 FIN: done=1 for exactly one cycle, then IDLE; minimum start-to-done latency (word_count=0) 2 cycles.
REQ-032 in_ready=0 and userWe=0 in every state other than WRITE.
REQ-033 userAddr in IDLE/FIN SHALL hold its last driven value; 0 after reset.
REQ-034 error and err_sum cleared on accepted start; otherwise held.

Reset
REQ-035 On rst high: state=IDLE, in_ready=0, userWe=0, userAddr=0, userWData=0, busy=0, done=0, error=0, err_sum=0, idx/wsum/rsum=0, asynchronously.
REQ-036 rst during any phase SHALL abort; no done pulse; no further writes; RAM contents already written are not restored.

Verification
REQ-037 base=0x4, count=1, verify_en=1, in_data=0x00110011 -> one write to 0x4, readback 0x00110011, done pulse, error=0.
REQ-038 base=0x0, count=4, data 1,2,3,4 with in_valid gapped every other cycle -> writes to 0x0,0x4,0x8,0xC only on valid cycles; wsum=10; error=0.
REQ-039 count=0 -> busy for 1 cycle, done 2 cycles after start, userWe never asserted.
REQ-040 count=2, verify_en=1, RAM model corrupts word at 0x4 to 0 -> error=1, err_sum=first word only.
REQ-041 base=0xFFFFFFFC, count=2 -> second write at 0x00000000.
REQ-042 rst asserted after 2 of 4 beats -> userWe low immediately, busy=0, no done; new start succeeds normally.
